// File: rtl/axis_shift_buffer.sv
// axis_shift_buffer: replays each input beat kernel_h_1+1 times, sliding an UNITS-word window per half
module axis_shift_buffer #(
    parameter int UNITS = 2,
    parameter int WORD_WIDTH = 8,
    parameter int KERNEL_H_MAX = 3,
    localparam int UNITS_EDGES = UNITS + KERNEL_H_MAX - 1,
    localparam int BITS_KERNEL_H_MAX = $clog2(KERNEL_H_MAX)
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    output logic                                  s_axis_tready,
    input  logic                                  s_axis_tvalid,
    input  logic                                  s_axis_tlast,
    input  logic [WORD_WIDTH*UNITS_EDGES*2-1:0]   s_axis_tdata,
    input  logic [BITS_KERNEL_H_MAX-1:0]          s_axis_tuser,
    input  logic                                  m_axis_tready,
    output logic                                  m_axis_tvalid,
    output logic                                  m_axis_tlast,
    output logic [WORD_WIDTH*UNITS*2-1:0]         m_axis_tdata,
    output logic [BITS_KERNEL_H_MAX-1:0]          m_axis_tuser
);
    localparam logic [BITS_KERNEL_H_MAX-1:0] KH_MAX_1 = BITS_KERNEL_H_MAX'(KERNEL_H_MAX - 1);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t                                state_q, state_d;
    logic [BITS_KERNEL_H_MAX-1:0]          k_q, k_d, kh_q, kh_d, kh_eff;
    logic [WORD_WIDTH*UNITS_EDGES*2-1:0]   data_q, data_d;
    logic                                  last_q, last_d;
    logic                                  last_shift, s_hs, m_hs;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= EMPTY;
            k_q     <= '0;
            kh_q    <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            kh_q    <= kh_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end
    always_comb begin
        kh_eff        = (s_axis_tuser > KH_MAX_1) ? KH_MAX_1 : s_axis_tuser;
        m_axis_tvalid = (state_q == FULL);
        last_shift    = m_axis_tvalid & (k_q == kh_q);
        s_axis_tready = !m_axis_tvalid | (last_shift & m_axis_tready);
        s_hs          = s_axis_tvalid & s_axis_tready;
        m_hs          = m_axis_tvalid & m_axis_tready;
        m_axis_tlast  = last_q & last_shift;
        m_axis_tuser  = kh_q;
        // a load in the same cycle as the final replay takes priority
        state_d = s_hs ? FULL : (m_hs & last_shift) ? EMPTY : state_q;
        k_d     = (s_hs | (m_hs & last_shift)) ? '0 : m_hs ? k_q + 1'b1 : k_q;
        kh_d    = s_hs ? kh_eff : kh_q;
        data_d  = s_hs ? s_axis_tdata : data_q;
        last_d  = s_hs ? s_axis_tlast : last_q;
        m_axis_tdata = '0;
        for (int h = 0; h < 2; h++)
            for (int u = 0; u < UNITS; u++)
                m_axis_tdata[(h*UNITS+u)*WORD_WIDTH +: WORD_WIDTH] =
                    data_q[(h*UNITS_EDGES+u+int'(k_q))*WORD_WIDTH +: WORD_WIDTH];
    end
endmodule

// File: tb/tb_axis_shift_buffer.sv
// tb_axis_shift_buffer: directed checks of replay, backpressure, back-to-back, saturation and async reset
module tb_axis_shift_buffer;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic        s_axis_tready, s_axis_tvalid, s_axis_tlast;
    logic [63:0] s_axis_tdata;
    logic [1:0]  s_axis_tuser;
    logic        m_axis_tready, m_axis_tvalid, m_axis_tlast;
    logic [31:0] m_axis_tdata;
    logic [1:0]  m_axis_tuser;
    int          total = 0, passed = 0, failed = 0;

    localparam logic [63:0] A = 64'h23222120_13121110;
    localparam logic [63:0] B = 64'h63626160_53525150;
    localparam logic [31:0] A0 = 32'h21201110, A1 = 32'h22211211, A2 = 32'h23221312;
    localparam logic [31:0] B0 = 32'h61605150, B1 = 32'h62615251, B2 = 32'h63625352;

    axis_shift_buffer dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tready(s_axis_tready), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
        .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic beat(input string tag, input logic [31:0] d, input logic l, input logic [1:0] u, input logic sr);
        #1;
        chk({tag, "_valid"}, 64'(m_axis_tvalid), 64'd1);
        chk({tag, "_data"}, 64'(m_axis_tdata), 64'(d));
        chk({tag, "_last"}, 64'(m_axis_tlast), 64'(l));
        chk({tag, "_user"}, 64'(m_axis_tuser), 64'(u));
        chk({tag, "_sready"}, 64'(s_axis_tready), 64'(sr));
    endtask

    task automatic idle(input string tag);
        #1;
        chk({tag, "_valid"}, 64'(m_axis_tvalid), 64'd0);
    endtask

    initial begin
        aresetn = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0; s_axis_tuser = '0;
        m_axis_tready = 1'b1;
        #12;
        chk("rst_valid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_last", 64'(m_axis_tlast), 64'd0);
        chk("rst_user", 64'(m_axis_tuser), 64'd0);
        chk("rst_data", 64'(m_axis_tdata), 64'd0);
        chk("rst_sready", 64'(s_axis_tready), 64'd1);
        tick();
        aresetn = 1'b1;
        tick();

        // 3x3 replay
        s_axis_tvalid = 1'b1; s_axis_tdata = A; s_axis_tuser = 2'd2; s_axis_tlast = 1'b1;
        #1 chk("r3_sready_in", 64'(s_axis_tready), 64'd1);
        tick();
        s_axis_tvalid = 1'b0;
        beat("r3_k0", A0, 1'b0, 2'd2, 1'b0); tick();
        beat("r3_k1", A1, 1'b0, 2'd2, 1'b0); tick();
        beat("r3_k2", A2, 1'b1, 2'd2, 1'b1); tick();
        idle("r3_done");

        // 1x1 back-to-back
        s_axis_tvalid = 1'b1; s_axis_tdata = A; s_axis_tuser = 2'd0; s_axis_tlast = 1'b1;
        tick();
        s_axis_tdata = B; s_axis_tlast = 1'b0;
        beat("r1_a", A0, 1'b1, 2'd0, 1'b1); tick();
        s_axis_tvalid = 1'b0;
        beat("r1_b", B0, 1'b0, 2'd0, 1'b1); tick();
        idle("r1_done");

        // backpressure with m_ready 1,0,0,1,1
        s_axis_tvalid = 1'b1; s_axis_tdata = A; s_axis_tuser = 2'd2; s_axis_tlast = 1'b0;
        tick();
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1; beat("bp_0", A0, 1'b0, 2'd2, 1'b0); tick();
        m_axis_tready = 1'b0; beat("bp_1", A1, 1'b0, 2'd2, 1'b0); tick();
        m_axis_tready = 1'b0; beat("bp_2", A1, 1'b0, 2'd2, 1'b0); tick();
        m_axis_tready = 1'b1; beat("bp_3", A1, 1'b0, 2'd2, 1'b0); tick();
        m_axis_tready = 1'b1; beat("bp_4", A2, 1'b0, 2'd2, 1'b1); tick();
        idle("bp_done");

        // back-to-back 3x3, B accepted with A's final replay
        s_axis_tvalid = 1'b1; s_axis_tdata = A; s_axis_tuser = 2'd2; s_axis_tlast = 1'b0;
        tick();
        s_axis_tdata = B; s_axis_tlast = 1'b1;
        beat("bb_a0", A0, 1'b0, 2'd2, 1'b0); tick();
        beat("bb_a1", A1, 1'b0, 2'd2, 1'b0); tick();
        beat("bb_a2", A2, 1'b0, 2'd2, 1'b1); tick();
        s_axis_tvalid = 1'b0;
        beat("bb_b0", B0, 1'b0, 2'd2, 1'b0); tick();
        beat("bb_b1", B1, 1'b0, 2'd2, 1'b0); tick();
        beat("bb_b2", B2, 1'b1, 2'd2, 1'b1); tick();
        idle("bb_done");

        // saturation: tuser=3 behaves as 2
        s_axis_tvalid = 1'b1; s_axis_tdata = A; s_axis_tuser = 2'd3; s_axis_tlast = 1'b0;
        tick();
        s_axis_tvalid = 1'b0;
        beat("sat_k0", A0, 1'b0, 2'd2, 1'b0); tick();
        beat("sat_k1", A1, 1'b0, 2'd2, 1'b0); tick();
        beat("sat_k2", A2, 1'b0, 2'd2, 1'b1); tick();
        idle("sat_done");

        // asynchronous reset mid-replay
        s_axis_tvalid = 1'b1; s_axis_tdata = A; s_axis_tuser = 2'd2; s_axis_tlast = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        beat("ar_k0", A0, 1'b0, 2'd2, 1'b0); tick();
        aresetn = 1'b0;
        #1;
        chk("ar_valid", 64'(m_axis_tvalid), 64'd0);
        chk("ar_data", 64'(m_axis_tdata), 64'd0);
        chk("ar_user", 64'(m_axis_tuser), 64'd0);
        chk("ar_last", 64'(m_axis_tlast), 64'd0);
        tick();
        aresetn = 1'b1;
        tick(); idle("ar_idle0");
        tick(); idle("ar_idle1");
        s_axis_tvalid = 1'b1; s_axis_tdata = B; s_axis_tuser = 2'd1; s_axis_tlast = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        beat("ar_b0", B0, 1'b0, 2'd1, 1'b0); tick();
        beat("ar_b1", B1, 1'b1, 2'd1, 1'b1); tick();
        idle("ar_done");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
